// File: rtl/phy_pkg.sv
// Shared PHY receive-path definitions: deserializer FSM state encodings,
// the K28.5 comma symbol and a counter-width helper.
package phy_pkg;

    typedef logic [1:0] state_t;

    localparam state_t HUNT   = 2'd0;
    localparam state_t ALIGN  = 2'd1;
    localparam state_t LOCKED = 2'd2;

    localparam logic [7:0] K28_5 = 8'hBC;

    // Bits needed to count up to the larger of two limits without wrapping.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sp_comma_detect.sv
// Serial shift register plus a comma comparator on the word that includes
// the bit being sampled at this edge.
module sp_comma_detect
    import phy_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] COMMA = K28_5
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] word_next,
    output logic             is_comma
);

    logic [WIDTH-1:0] sr;

    assign word_next = {sr[WIDTH-2:0], data_in};
    assign is_comma  = (word_next == COMMA);

    always_ff @(posedge clk_32f) begin
        if (!reset) sr <= '0;
        else        sr <= word_next;
    end

endmodule

// File: rtl/serial_paralelo_align.sv
// 1-bit to WIDTH deserializer: hunts for the comma at any bit offset, locks
// after LOCK_COUNT aligned commas and emits words held for one word period.
module serial_paralelo_align
    import phy_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = K28_5,
    parameter int               LOCK_COUNT = 4,
    parameter int               MAX_GAP    = 0
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    output logic             comma_out,
    output logic             locked
);

    localparam int             CW       = $clog2(WIDTH);
    localparam int             GW       = cnt_width(LOCK_COUNT, MAX_GAP);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0]  LOCK_N   = GW'(LOCK_COUNT);
    localparam logic [GW-1:0]  GAP_N    = GW'(MAX_GAP);

    logic [WIDTH-1:0] word_next;
    logic             is_comma;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    ccnt_q, ccnt_d, gap_q, gap_d;
    logic [GW-1:0]    ccnt_inc, gap_inc;
    logic             boundary, gap_drop;
    logic             valid_d, comma_d, locked_d;
    logic [WIDTH-1:0] data_d;

    sp_comma_detect #(.WIDTH(WIDTH), .COMMA(COMMA)) u_detect (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .word_next(word_next),
        .is_comma (is_comma)
    );

    assign boundary = (cnt_q == CNT_LAST);
    assign ccnt_inc = ccnt_q + GW'(1);
    assign gap_inc  = (gap_q == {GW{1'b1}}) ? gap_q : gap_q + GW'(1);
    assign gap_drop = (MAX_GAP != 0) && (gap_inc >= GAP_N);

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state_q   <= HUNT;
            cnt_q     <= '0;
            ccnt_q    <= '0;
            gap_q     <= '0;
            valid_out <= 1'b0;
            comma_out <= 1'b0;
            locked    <= 1'b0;
            data_out  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ccnt_q    <= ccnt_d;
            gap_q     <= gap_d;
            valid_out <= valid_d;
            comma_out <= comma_d;
            locked    <= locked_d;
            data_out  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT:   if (is_comma) state_d = (LOCK_COUNT == 1) ? LOCKED : ALIGN;
            ALIGN:  if (boundary) begin
                        if (!is_comma)               state_d = HUNT;
                        else if (ccnt_inc >= LOCK_N) state_d = LOCKED;
                    end
            LOCKED: if (boundary && !is_comma && gap_drop) state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    // valid_out has no ready: it is a level held for a whole word period,
    // set only for data words while locked, so a slower clock can sample it.
    always_comb begin
        cnt_d    = boundary ? '0 : cnt_q + 1'b1;
        ccnt_d   = ccnt_q;
        gap_d    = gap_q;
        valid_d  = valid_out;
        comma_d  = comma_out;
        locked_d = locked;
        data_d   = data_out;
        case (state_q)
            HUNT: begin
                valid_d  = 1'b0;
                comma_d  = 1'b0;
                locked_d = 1'b0;
                if (is_comma) begin
                    cnt_d  = '0;
                    ccnt_d = GW'(1);
                    if (LOCK_COUNT == 1) begin
                        locked_d = 1'b1;
                        comma_d  = 1'b1;
                        gap_d    = '0;
                    end
                end
            end
            ALIGN: begin
                valid_d = 1'b0;
                if (boundary) begin
                    if (is_comma) begin
                        ccnt_d = ccnt_inc;
                        if (ccnt_inc >= LOCK_N) begin
                            locked_d = 1'b1;
                            comma_d  = 1'b1;
                            gap_d    = '0;
                        end
                    end else begin
                        ccnt_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    if (is_comma) begin
                        valid_d = 1'b0;
                        comma_d = 1'b1;
                        gap_d   = '0;
                    end else if (gap_drop) begin
                        locked_d = 1'b0;
                        valid_d  = 1'b0;
                        comma_d  = 1'b0;
                        data_d   = '0;
                        gap_d    = '0;
                        ccnt_d   = '0;
                    end else begin
                        data_d  = word_next;
                        valid_d = 1'b1;
                        comma_d = 1'b0;
                        gap_d   = gap_inc;
                    end
                end
            end
            default: begin
                valid_d  = 1'b0;
                comma_d  = 1'b0;
                locked_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_paralelo_align.sv
// Bench for serial_paralelo_align: two instances (lock never dropped, and
// MAX_GAP=16) fed the same serial stream, checked word by word.
module tb_serial_paralelo_align;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic       va, ca, la, vb, cb, lb;
    logic [7:0] da, db;

    typedef struct {
        logic [7:0]  word;
        logic [10:0] exp_a;
        logic [10:0] exp_b;
    } vec_t;

    vec_t        tbl[$];
    logic [21:0] exp_q[$];
    logic [10:0] prev_a, prev_b;
    int          n_checks = 0;
    int          n_fail   = 0;

    localparam logic [10:0] Z = 11'd0;

    always #5 clk_32f = ~clk_32f;

    serial_paralelo_align #(.WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(4), .MAX_GAP(0)) dut_a (
        .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
        .valid_out(va), .data_out(da), .comma_out(ca), .locked(la)
    );

    serial_paralelo_align #(.WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(4), .MAX_GAP(16)) dut_b (
        .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
        .valid_out(vb), .data_out(db), .comma_out(cb), .locked(lb)
    );

    function automatic logic [10:0] e(input logic l, input logic v, input logic c, input logic [7:0] d);
        return {l, v, c, d};
    endfunction

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got locked=%b valid=%b comma=%b data=%h, expected locked=%b valid=%b comma=%b data=%h",
                     name, got[10], got[9], got[8], got[7:0], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic check_both(input string name, input logic [10:0] ea, input logic [10:0] eb);
        check($sformatf("%s dut_a", name), {la, va, ca, da}, ea);
        check($sformatf("%s dut_b", name), {lb, vb, cb, db}, eb);
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    // Outputs must hold through the first WIDTH-1 bits, then update on the last.
    task automatic send_word(input logic [7:0] w, input logic [10:0] ea, input logic [10:0] eb, input string tag);
        logic [21:0] exp;
        exp_q.push_back({ea, eb});
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i]);
            if (i != 0) check_both($sformatf("%s hold bit%0d", tag, 7 - i), prev_a, prev_b);
        end
        exp = exp_q.pop_front();
        check_both(tag, exp[21:11], exp[10:0]);
        prev_a = ea;
        prev_b = eb;
    endtask

    task automatic add(input logic [7:0] w, input logic [10:0] ea, input logic [10:0] eb);
        vec_t v;
        v.word  = w;
        v.exp_a = ea;
        v.exp_b = eb;
        tbl.push_back(v);
    endtask

    task automatic run_table(input string name);
        foreach (tbl[i])
            send_word(tbl[i].word, tbl[i].exp_a, tbl[i].exp_b, $sformatf("%s w%0d", name, i));
        tbl.delete();
    endtask

    task automatic do_reset(input int n, input string name);
        reset = 1'b0;
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
        check_both(name, Z, Z);
        reset  = 1'b1;
        prev_a = Z;
        prev_b = Z;
    endtask

    initial begin
        // Test 1: reset with random data
        do_reset(10, "t1 reset");

        // Test 2: offset 0 lock, data word held a full period
        add(8'hBC, Z, Z);
        add(8'hBC, Z, Z);
        add(8'hBC, Z, Z);
        add(8'hBC, e(1, 0, 1, 8'h00), e(1, 0, 1, 8'h00));
        add(8'h5A, e(1, 1, 0, 8'h5A), e(1, 1, 0, 8'h5A));
        add(8'hBC, e(1, 0, 1, 8'h5A), e(1, 0, 1, 8'h5A));
        run_table("t2");

        // Test 3: three junk bits shift the word alignment
        do_reset(2, "t3 reset");
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check_both("t3 junk", Z, Z);
        add(8'hBC, Z, Z);
        add(8'hBC, Z, Z);
        add(8'hBC, Z, Z);
        add(8'hBC, e(1, 0, 1, 8'h00), e(1, 0, 1, 8'h00));
        add(8'hA5, e(1, 1, 0, 8'hA5), e(1, 1, 0, 8'hA5));
        add(8'hBC, e(1, 0, 1, 8'hA5), e(1, 0, 1, 8'hA5));
        run_table("t3");

        // Test 4: broken comma run restarts the count
        do_reset(2, "t4 reset");
        add(8'hBC, Z, Z);
        add(8'hBC, Z, Z);
        add(8'h00, Z, Z);
        add(8'hBC, Z, Z);
        add(8'hBC, Z, Z);
        add(8'hBC, Z, Z);
        add(8'hBC, e(1, 0, 1, 8'h00), e(1, 0, 1, 8'h00));
        add(8'h3C, e(1, 1, 0, 8'h3C), e(1, 1, 0, 8'h3C));
        run_table("t4");

        // Test 5: 16 data words without a comma; only dut_b drops lock
        do_reset(2, "t5 reset");
        add(8'hBC, Z, Z);
        add(8'hBC, Z, Z);
        add(8'hBC, Z, Z);
        add(8'hBC, e(1, 0, 1, 8'h00), e(1, 0, 1, 8'h00));
        for (int k = 1; k <= 16; k++)
            add(8'h11, e(1, 1, 0, 8'h11), (k == 16) ? Z : e(1, 1, 0, 8'h11));
        add(8'hBC, e(1, 0, 1, 8'h11), Z);
        add(8'hBC, e(1, 0, 1, 8'h11), Z);
        add(8'hBC, e(1, 0, 1, 8'h11), Z);
        add(8'hBC, e(1, 0, 1, 8'h11), e(1, 0, 1, 8'h00));
        add(8'h77, e(1, 1, 0, 8'h77), e(1, 1, 0, 8'h77));
        run_table("t5");

        // Test 6: one-cycle reset in the middle of a locked word
        do_reset(2, "t6 reset");
        add(8'hBC, Z, Z);
        add(8'hBC, Z, Z);
        add(8'hBC, Z, Z);
        add(8'hBC, e(1, 0, 1, 8'h00), e(1, 0, 1, 8'h00));
        add(8'h5A, e(1, 1, 0, 8'h5A), e(1, 1, 0, 8'h5A));
        run_table("t6 pre");
        for (int i = 0; i < 3; i++) begin
            send_bit(1'($urandom_range(0, 1)));
            check_both($sformatf("t6 partial bit%0d", i), prev_a, prev_b);
        end
        do_reset(1, "t6 midword reset");
        add(8'hBC, Z, Z);
        add(8'hBC, Z, Z);
        add(8'hBC, Z, Z);
        add(8'hBC, e(1, 0, 1, 8'h00), e(1, 0, 1, 8'h00));
        add(8'hC3, e(1, 1, 0, 8'hC3), e(1, 1, 0, 8'hC3));
        run_table("t6 relock");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
